ddr_crc5_gen: RTL and testbench

Bit-serial CRC-5 engine for the HDR-DDR normal-transaction path. It sits directly downstream of the DDR engine's CRC byte port (`o_crc_en` / `o_crc_parallel_data`) and directly upstream of its CRC inputs (`i_crc_crc_value` / `i_crc_valid`). It accumulates the I3C CRC-5 over every data byte of a frame and presents the final 5-bit word for the TX CRC token. In RX it also compares the computed word against the received CRC and flags a mismatch.

---
 rtl/i3c_ddr_pkg.sv | 23 ++
 rtl/ddr_crc5_gen.sv | 124 ++++++++++++
 tb/tb_ddr_crc5_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i3c_ddr_pkg.sv
// Shared HDR-DDR definitions: CRC-5 constants,
// engine state encoding and a single-bit CRC step.
package i3c_ddr_pkg;

    localparam logic [4:0] CRC5_SEED = 5'h1F;
    localparam logic [4:0] CRC5_POLY = 5'h05;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } crc_state_e;

    function automatic logic [4:0] crc5_step(
        input logic [4:0] crc,
        input logic       din
    );
        logic fb;
        fb = crc[4] ^ din;
        return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
    endfunction

endpackage

// File: rtl/ddr_crc5_gen.sv
// Bit-serial I3C CRC-5 engine: one data bit per clock,
// final word and RX mismatch flag pulsed after the last byte.
module ddr_crc5_gen
    import i3c_ddr_pkg::*;
#(
    parameter int             DATA_W = 8,
    parameter int             CRC_W  = 5,
    parameter logic [CRC_W-1:0] SEED = CRC_W'(CRC5_SEED),
    parameter logic [CRC_W-1:0] POLY = CRC_W'(CRC5_POLY)
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_crc_init,
    input  logic              i_crc_en,
    input  logic [DATA_W-1:0] i_crc_parallel_data,
    input  logic              i_crc_last,
    input  logic              i_rx_check,
    input  logic [CRC_W-1:0]  i_rx_crc,
    output logic              o_crc_busy,
    output logic [CRC_W-1:0]  o_crc_value,
    output logic              o_crc_valid,
    output logic              o_crc_error
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    crc_state_e        state, state_n;
    logic [CRC_W-1:0]  crc, crc_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] sreg, sreg_n;
    logic              last_q, last_n;
    logic              chk_q, chk_n;
    logic              valid_q, valid_n;
    logic              err_q, err_n;
    logic              fb;
    logic [CRC_W-1:0]  crc_step;

    // One CRC step driven by the MSB of the latched byte.
    always_comb begin
        fb       = crc[CRC_W-1] ^ sreg[DATA_W-1];
        crc_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    // Next-state and datapath; the mismatch flag is resolved on
    // the edge into DONE so every output leaves a flop.
    always_comb begin
        state_n = state;
        crc_n   = crc;
        cnt_n   = cnt;
        sreg_n  = sreg;
        last_n  = last_q;
        chk_n   = chk_q;
        valid_n = 1'b0;
        err_n   = 1'b0;
        if (i_crc_init) begin
            state_n = IDLE;
            crc_n   = SEED;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_crc_en) begin
                        state_n = SHIFT;
                        sreg_n  = i_crc_parallel_data;
                        last_n  = i_crc_last;
                        chk_n   = i_rx_check;
                        cnt_n   = '0;
                    end
                end
                SHIFT: begin
                    crc_n  = crc_step;
                    sreg_n = {sreg[DATA_W-2:0], 1'b0};
                    cnt_n  = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        if (last_q) begin
                            state_n = DONE;
                            valid_n = 1'b1;
                            err_n   = chk_q & (crc_step != i_rx_crc);
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                DONE: begin
                    state_n = IDLE;
                    crc_n   = SEED;
                end
                default: begin
                    state_n = IDLE;
                    crc_n   = SEED;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state   <= IDLE;
            crc     <= SEED;
            cnt     <= '0;
            sreg    <= '0;
            last_q  <= 1'b0;
            chk_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            crc     <= crc_n;
            cnt     <= cnt_n;
            sreg    <= sreg_n;
            last_q  <= last_n;
            chk_q   <= chk_n;
            valid_q <= valid_n;
            err_q   <= err_n;
        end
    end

    assign o_crc_busy  = (state == SHIFT);
    assign o_crc_value = crc;
    assign o_crc_valid = valid_q;
    assign o_crc_error = err_q;

endmodule

// File: tb/tb_ddr_crc5_gen.sv
// Self-checking bench for ddr_crc5_gen: directed cases plus
// random frames against a polynomial-division reference.
module tb_ddr_crc5_gen;

    logic       clk;
    logic       rst_n;
    logic       init;
    logic       en;
    logic [7:0] data;
    logic       last;
    logic       rx_check;
    logic [4:0] rx_crc;
    logic       busy;
    logic [4:0] value;
    logic       valid;
    logic       error;

    int checks = 0;
    int errors = 0;

    ddr_crc5_gen dut (
        .i_sys_clk           (clk),
        .i_sys_rst           (rst_n),
        .i_crc_init          (init),
        .i_crc_en            (en),
        .i_crc_parallel_data (data),
        .i_crc_last          (last),
        .i_rx_check          (rx_check),
        .i_rx_crc            (rx_crc),
        .o_crc_busy          (busy),
        .o_crc_value         (value),
        .o_crc_valid         (valid),
        .o_crc_error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of (SEED*x^n + M(x)*x^5) mod (x^5+x^2+1).
    function automatic logic [4:0] ref_crc(
        input logic [31:0] msg,
        input int          nbytes
    );
        longint unsigned v;
        longint unsigned m;
        int nb;
        nb = nbytes * 8;
        m  = longint'(msg) & ((64'd1 << nb) - 64'd1);
        v  = (64'h1F << nb) ^ (m << 5);
        for (int i = nb + 4; i >= 5; i--)
            if (v[i]) v = v ^ (64'h25 << (i - 5));
        return v[4:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one byte and follows it through the shift phase.
    task automatic send_byte(
        input string      tag,
        input logic [7:0] b,
        input logic       lst
    );
        int nbusy;
        en   = 1'b1;
        data = b;
        last = lst;
        step();
        en   = 1'b0;
        data = 8'h00;
        last = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) nbusy++;
            step();
        end
        check({tag, " busy"}, nbusy, 8);
        check({tag, " idle"}, busy, 0);
    endtask

    // Valid must never rise within a window of n cycles.
    task automatic no_valid(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (valid !== 1'b0) seen++;
            step();
        end
        check(tag, seen, 0);
    endtask

    task automatic run_frame(
        input string       tag,
        input logic [31:0] msg,
        input int          n,
        input logic        chk,
        input logic [4:0]  rx
    );
        logic [4:0] exp;
        exp      = ref_crc(msg, n);
        rx_check = chk;
        rx_crc   = rx;
        for (int k = n - 1; k >= 0; k--) begin
            logic [7:0] b;
            b = msg[k*8 +: 8];
            send_byte(tag, b, k == 0);
        end
        check({tag, " valid"}, valid, 1);
        check({tag, " value"}, value, exp);
        check({tag, " error"}, error, chk & (exp != rx));
        step();
        check({tag, " valid drop"}, valid, 0);
        check({tag, " error drop"}, error, 0);
        check({tag, " seed"}, value, 5'h1F);
        rx_check = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        init     = 1'b0;
        en       = 1'b0;
        data     = 8'h00;
        last     = 1'b0;
        rx_check = 1'b0;
        rx_crc   = 5'h00;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("reset value", value, 5'h1F);
        check("reset busy", busy, 0);
        check("reset valid", valid, 0);
        check("reset error", error, 0);

        init = 1'b1;
        step();
        init = 1'b0;
        run_frame("zero byte", 32'h00, 1, 1'b0, 5'h00);
        check("ref zero", ref_crc(32'h00, 1), 5'h0F);

        run_frame("two byte", 32'h000A, 2, 1'b1, 5'h06);
        check("ref two", ref_crc(32'h000A, 2), 5'h06);

        run_frame("mismatch", 32'h0A, 1, 1'b1, 5'h00);
        check("ref mis", ref_crc(32'h0A, 1), 5'h08);

        // Strobe while busy must be dropped.
        en   = 1'b1;
        data = 8'h00;
        last = 1'b1;
        step();
        en   = 1'b0;
        last = 1'b0;
        step();
        step();
        en   = 1'b1;
        data = 8'hFF;
        last = 1'b1;
        step();
        en   = 1'b0;
        last = 1'b0;
        repeat (5) step();
        check("collide valid", valid, 1);
        check("collide value", value, 5'h0F);
        step();
        no_valid("collide no extra", 12);

        // Init mid-shift aborts the byte.
        en   = 1'b1;
        data = 8'h5A;
        last = 1'b1;
        step();
        en   = 1'b0;
        last = 1'b0;
        repeat (3) step();
        init = 1'b1;
        step();
        init = 1'b0;
        check("init value", value, 5'h1F);
        check("init busy", busy, 0);
        no_valid("init no valid", 12);

        // Asynchronous reset mid-shift.
        en   = 1'b1;
        data = 8'hA5;
        last = 1'b1;
        step();
        en   = 1'b0;
        last = 1'b0;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst value", value, 5'h1F);
        check("rst busy", busy, 0);
        step();
        rst_n = 1'b1;
        no_valid("rst no valid", 12);

        // Init and strobe together: byte dropped.
        init = 1'b1;
        en   = 1'b1;
        data = 8'h33;
        last = 1'b1;
        step();
        init = 1'b0;
        en   = 1'b0;
        last = 1'b0;
        check("init+en busy", busy, 0);
        no_valid("init+en no valid", 12);

        // Frame without last: no completion pulse.
        send_byte("no last", 8'hC3, 1'b0);
        check("no last value", value, ref_crc(32'hC3, 1));
        no_valid("no last pulse", 12);
        init = 1'b1;
        step();
        init = 1'b0;

        for (int f = 0; f < 20; f++) begin
            int          n;
            logic [31:0] msg;
            logic [4:0]  rx;
            logic        chk;
            n   = $urandom_range(1, 4);
            msg = $urandom;
            if (n < 4) msg = msg & ((32'd1 << (n * 8)) - 32'd1);
            chk = 1'($urandom_range(0, 1));
            rx  = ($urandom_range(0, 1) == 1) ? ref_crc(msg, n)
                                              : 5'($urandom);
            run_frame($sformatf("rand%0d", f), msg, n, chk, rx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
